sync_fifo_flags: RTL

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

---
 rtl/sync_fifo_flags_if.sv | 32 +++
 rtl/sync_fifo_flags.sv | 103 ++++++++++
 2 files changed

// File: rtl/sync_fifo_flags_if.sv
// Request/response bundle for sync_fifo_flags: write/read/flush requests in,
// registered read data plus level and sticky error flags out.
interface sync_fifo_flags_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  Wr_enable;
    logic                  Read_enable;
    logic                  flush;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output Wr_enable, Read_enable, flush, data_in,
        input  data_out, data_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  Wr_enable, Read_enable, flush, data_in,
        output data_out, data_valid, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered read data, level flags derived from count,
// and sticky overflow/underflow cleared only by rst or flush.
module sync_fifo_flags #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned AF_LEVEL   = 2**ADDR_WIDTH - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input logic               clk,
    input logic               rst,
    sync_fifo_flags_if.slave  bus
);
    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH:0] DepthCnt = CNT_W'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AfCnt    = CNT_W'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AeCnt    = CNT_W'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic full, empty, wr_ok, rd_ok;

    assign full  = (count_q == DepthCnt);
    assign empty = (count_q == '0);
    assign wr_ok = bus.Wr_enable && !full && !bus.flush;
    assign rd_ok = bus.Read_enable && !empty && !bus.flush;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        if (bus.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok) begin
                rd_ptr_d     = rd_ptr_q + 1'b1;
                data_out_d   = mem[rd_ptr_q];
                data_valid_d = 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count_d = count_q + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - 1'b1;
            end
            if (bus.Wr_enable && full) overflow_d = 1'b1;
            // A read at empty paired with a write is not an error: the write fills the slot.
            if (bus.Read_enable && empty && !bus.Wr_enable) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= bus.data_in;
    end

    assign bus.data_out     = data_out_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AfCnt);
    assign bus.almost_empty = (count_q <= AeCnt);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
